// File: rtl/row_decoder_5p_plus.sv
// Row-encoder packet stream decoder.
// Rebuilds pixel events with 30-bit time and flags protocol errors.
module row_decoder_5p_plus #(
  parameter int PIX_W = 3,
  parameter int N_PIX = 5,
  parameter int TS_W  = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [TS_W:0]          in_data,
  output logic                   pix_valid,
  output logic [PIX_W*N_PIX-1:0] pix_out,
  output logic                   pix_timed,
  output logic [2*TS_W-1:0]      pix_time,
  output logic                   wrap_seen,
  output logic [TS_W-1:0]        time_hi,
  output logic                   proto_err,
  output logic [15:0]            evt_cnt
);

  localparam int PW = PIX_W * N_PIX;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    RUN     = 2'd1,
    TS_PEND = 2'd2,
    WRAP    = 2'd3
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [TS_W-1:0] time_lo;
  logic [PW-1:0]   last_pix;

  logic            is_raw;
  logic            is_mk;
  logic [TS_W-1:0] pay;
  logic            ev;
  logic            ev_timed;
  logic            lo_we;
  logic [TS_W-1:0] lo_d;
  logic            hi_we;
  logic            seq_err;
  logic            rep_err;
  logic [TS_W-1:0] ev_lo;

  assign pay    = in_data[TS_W-1:0];
  assign is_raw = ~in_data[TS_W];
  assign is_mk  = in_data[TS_W] && (pay == '0);

  // Packet classification against the current state.
  always_comb begin
    nxt      = state;
    ev       = 1'b0;
    ev_timed = 1'b0;
    lo_we    = 1'b0;
    lo_d     = pay;
    hi_we    = 1'b0;
    seq_err  = 1'b0;
    unique case (state)
      SYNC, RUN: begin
        if (is_raw) begin
          ev  = 1'b1;
          nxt = RUN;
        end else if (is_mk) begin
          nxt = WRAP;
        end else begin
          lo_we = 1'b1;
          nxt   = TS_PEND;
        end
      end
      TS_PEND: begin
        if (is_raw) begin
          ev       = 1'b1;
          ev_timed = 1'b1;
          nxt      = RUN;
        end else if (is_mk) begin
          seq_err = 1'b1;
          nxt     = WRAP;
        end else begin
          seq_err = 1'b1;
          lo_we   = 1'b1;
        end
      end
      WRAP: begin
        lo_we = 1'b1;
        lo_d  = '0;
        nxt   = RUN;
        if (is_raw) begin
          ev       = 1'b1;
          ev_timed = 1'b1;
        end else begin
          hi_we = 1'b1;
        end
      end
      default: nxt = SYNC;
    endcase
  end

  // Repeated raw packet check and event time selection.
  always_comb begin
    rep_err = ev && (state != SYNC) && (pay == last_pix);
    ev_lo   = lo_we ? lo_d : time_lo;
  end

  // State, time registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SYNC;
      time_lo   <= '0;
      time_hi   <= '0;
      last_pix  <= '0;
      pix_valid <= 1'b0;
      pix_out   <= '0;
      pix_timed <= 1'b0;
      pix_time  <= '0;
      wrap_seen <= 1'b0;
      proto_err <= 1'b0;
      evt_cnt   <= '0;
    end else begin
      pix_valid <= 1'b0;
      wrap_seen <= 1'b0;
      proto_err <= 1'b0;
      if (in_valid) begin
        state     <= nxt;
        proto_err <= seq_err | rep_err;
        if (lo_we) time_lo <= lo_d;
        if (hi_we) begin
          time_hi   <= pay;
          wrap_seen <= 1'b1;
        end
        if (ev) begin
          pix_valid <= 1'b1;
          pix_out   <= pay;
          last_pix  <= pay;
          pix_timed <= ev_timed;
          pix_time  <= {time_hi, ev_lo};
          evt_cnt   <= evt_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_row_decoder_5p_plus.sv
// Bench for row_decoder_5p_plus.
// Directed table, corner sequences and random packets vs a model.
module tb_row_decoder_5p_plus;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        pix_valid;
  logic [14:0] pix_out;
  logic        pix_timed;
  logic [29:0] pix_time;
  logic        wrap_seen;
  logic [14:0] time_hi;
  logic        proto_err;
  logic [15:0] evt_cnt;

  row_decoder_5p_plus dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data),
    .pix_valid(pix_valid), .pix_out(pix_out),
    .pix_timed(pix_timed), .pix_time(pix_time),
    .wrap_seen(wrap_seen), .time_hi(time_hi),
    .proto_err(proto_err), .evt_cnt(evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: protocol flags, not the RTL state encoding.
  logic        m_left_sync;
  logic        m_ts_pend;
  logic        m_wrap_pend;
  logic [14:0] m_lo, m_hi, m_last;
  logic        m_pv, m_ws, m_pe, m_timed;
  logic [14:0] m_pix;
  logic [29:0] m_time;
  logic [15:0] m_cnt;

  task automatic model_step(input logic r, input logic v,
                            input logic [15:0] d);
    logic [14:0] p;
    p = d[14:0];
    m_pv = 0; m_ws = 0; m_pe = 0;
    if (!r) begin
      m_left_sync = 0; m_ts_pend = 0; m_wrap_pend = 0;
      m_lo = 0; m_hi = 0; m_last = 0;
      m_timed = 0; m_pix = 0; m_time = 0; m_cnt = 0;
    end else if (v) begin
      if (!d[15]) begin
        if (m_left_sync || m_ts_pend || m_wrap_pend)
          if (p == m_last) m_pe = 1;
        if (m_wrap_pend) m_lo = 0;
        m_timed = m_ts_pend || m_wrap_pend;
        m_time = m_hi * 32768 + m_lo;
        m_pix = p; m_last = p;
        m_cnt = m_cnt + 1;
        m_pv = 1;
        m_left_sync = 1; m_ts_pend = 0; m_wrap_pend = 0;
      end else if (m_wrap_pend) begin
        m_hi = p; m_lo = 0; m_ws = 1;
        m_wrap_pend = 0; m_left_sync = 1;
      end else if (p == 0) begin
        if (m_ts_pend) m_pe = 1;
        m_ts_pend = 0; m_wrap_pend = 1;
      end else begin
        if (m_ts_pend) m_pe = 1;
        m_lo = p; m_ts_pend = 1;
      end
    end
  endtask

  task automatic check_model();
    check("pix_valid", 32'(pix_valid), 32'(m_pv));
    check("pix_out", 32'(pix_out), 32'(m_pix));
    check("pix_timed", 32'(pix_timed), 32'(m_timed));
    check("pix_time", 32'(pix_time), 32'(m_time));
    check("wrap_seen", 32'(wrap_seen), 32'(m_ws));
    check("time_hi", 32'(time_hi), 32'(m_hi));
    check("proto_err", 32'(proto_err), 32'(m_pe));
    check("evt_cnt", 32'(evt_cnt), 32'(m_cnt));
  endtask

  task automatic cycle(input logic r, input logic v,
                       input logic [15:0] d);
    @(negedge clk);
    rst_n = r; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
    model_step(r, v, d);
    check_model();
  endtask

  typedef struct {
    logic        r;
    logic        v;
    logic [15:0] d;
    logic        pv;
    logic [14:0] pix;
    logic        tm;
    logic [29:0] t;
    logic        ws;
    logic [14:0] hi;
    logic        pe;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mkv(
    logic r, logic v, logic [15:0] d, logic pv,
    logic [14:0] pix, logic tm, logic [29:0] t,
    logic ws, logic [14:0] hi, logic pe, logic [15:0] cnt);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.pv = pv;
    x.pix = pix; x.tm = tm; x.t = t; x.ws = ws;
    x.hi = hi; x.pe = pe; x.cnt = cnt;
    return x;
  endfunction

  vec_t tbl[12];

  initial begin
    rst_n = 0; in_valid = 0; in_data = 0;
    model_step(0, 0, 0);

    tbl[0]  = mkv(0,0,16'h0000, 0,15'h0000,0,30'h0,    0,15'd0,0,16'd0);
    tbl[1]  = mkv(1,1,16'h1234, 1,15'h1234,0,30'h0,    0,15'd0,0,16'd1);
    tbl[2]  = mkv(1,1,16'h8005, 0,15'h1234,0,30'h0,    0,15'd0,0,16'd1);
    tbl[3]  = mkv(1,1,16'h0A00, 1,15'h0A00,1,30'h5,    0,15'd0,0,16'd2);
    tbl[4]  = mkv(1,1,16'h8000, 0,15'h0A00,1,30'h5,    0,15'd0,0,16'd2);
    tbl[5]  = mkv(1,1,16'h8003, 0,15'h0A00,1,30'h5,    1,15'd3,0,16'd2);
    tbl[6]  = mkv(1,1,16'h0001, 1,15'h0001,0,30'h18000,0,15'd3,0,16'd3);
    tbl[7]  = mkv(1,1,16'h8000, 0,15'h0001,0,30'h18000,0,15'd3,0,16'd3);
    tbl[8]  = mkv(1,1,16'h0042, 1,15'h0042,1,30'h18000,0,15'd3,0,16'd4);
    tbl[9]  = mkv(1,1,16'h8010, 0,15'h0042,1,30'h18000,0,15'd3,0,16'd4);
    tbl[10] = mkv(1,1,16'h8020, 0,15'h0042,1,30'h18000,0,15'd3,1,16'd4);
    tbl[11] = mkv(1,1,16'h0042, 1,15'h0042,1,30'h18020,0,15'd3,1,16'd5);

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].d);
      check("tbl_pv", 32'(pix_valid), 32'(tbl[i].pv));
      check("tbl_pix", 32'(pix_out), 32'(tbl[i].pix));
      check("tbl_timed", 32'(pix_timed), 32'(tbl[i].tm));
      check("tbl_time", 32'(pix_time), 32'(tbl[i].t));
      check("tbl_ws", 32'(wrap_seen), 32'(tbl[i].ws));
      check("tbl_hi", 32'(time_hi), 32'(tbl[i].hi));
      check("tbl_pe", 32'(proto_err), 32'(tbl[i].pe));
      check("tbl_cnt", 32'(evt_cnt), 32'(tbl[i].cnt));
    end

    // Long idle gap between timestamp and raw packet.
    cycle(1, 1, 16'h8007);
    repeat (100) cycle(1, 0, 16'h0);
    cycle(1, 1, 16'h0100);
    check("gap_pv", 32'(pix_valid), 32'd1);
    check("gap_timed", 32'(pix_timed), 32'd1);
    check("gap_time", 32'(pix_time), 32'h18007);
    check("gap_pe", 32'(proto_err), 32'd0);

    // Reset while a timestamp is pending.
    cycle(1, 1, 16'h8009);
    cycle(0, 0, 16'h0);
    check("rst_cnt", 32'(evt_cnt), 32'd0);
    check("rst_hi", 32'(time_hi), 32'd0);
    check("rst_time", 32'(pix_time), 32'd0);
    cycle(1, 1, 16'h0123);
    check("rst_timed", 32'(pix_timed), 32'd0);
    check("rst_ev_time", 32'(pix_time), 32'd0);
    check("rst_ev_cnt", 32'(evt_cnt), 32'd1);

    // Random packet mix.
    for (int i = 0; i < 3000; i++) begin
      int p;
      logic [15:0] d;
      p = $urandom_range(0, 99);
      if (p < 2) begin
        cycle(0, 0, 16'h0);
      end else if (p < 15) begin
        cycle(1, 0, 16'($urandom));
      end else if (p < 55) begin
        d = 16'($urandom_range(0, 7));
        cycle(1, 1, d);
      end else if (p < 80) begin
        d = 16'h8000 | 16'($urandom_range(1, 32767));
        cycle(1, 1, d);
      end else begin
        cycle(1, 1, 16'h8000);
      end
    end

    // Event counter wrap.
    cycle(0, 0, 16'h0);
    for (int i = 0; i < 65536; i++)
      cycle(1, 1, 16'((i % 32767) + 1));
    check("cnt_wrap", 32'(evt_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
